rc4_prga_decrypt: RTL and testbench

- Downstream stage of the S-memory key-schedule (init + shuffle) FSMs.
- Once the shuffle stage finishes, this block owns the 256-byte S memory and runs the RC4 pseudo-random generation algorithm (PRGA).
- Each keystream byte is XORed with one encrypted-message ROM byte; the result is written to the decrypted-message RAM.
- It also reports whether every decrypted byte is a lowercase letter or space, which drives the key-search controller.

---
 rtl/rc4_prga_decrypt.sv | 152 +++++++++++++++
 tb/tb_rc4_prga_decrypt.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_prga_decrypt.sv
`default_nettype none
// ============================================================================
// rc4_prga_decrypt : RC4 PRGA over the shared S memory; XORs each keystream
//                    byte with the encrypted ROM and flags non-text output.
// Rev 1.0
// ============================================================================
module rc4_prga_decrypt #(
  parameter int MSG_LEN      = 32,
  parameter int ABORT_ON_BAD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       fin,
  output logic       busy,
  output logic       key_valid,
  output logic [7:0] s_addr,
  output logic [7:0] s_wr_data,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [4:0] enc_addr,
  input  logic [7:0] enc_q,
  output logic [4:0] dec_addr,
  output logic [7:0] dec_data,
  output logic       dec_wren
);

  localparam logic [8:0] LAST_K = 9'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, RD_SI, WT_SI, LD_SI, RD_SJ, WT_SJ, LD_SJ,
    WR_SI, WR_SJ, RD_F, WT_F, LD_F, WR_DEC, DONE
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] i, j, si, sj, f, enc_b;
  logic [8:0] k;
  logic [7:0] dec_byte;
  logic       dec_good;

  assign dec_byte = f ^ enc_b;
  assign dec_good = ((dec_byte >= 8'h61) && (dec_byte <= 8'h7A)) || (dec_byte == 8'h20);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = RD_SI;
      RD_SI:  state_nxt = WT_SI;
      WT_SI:  state_nxt = LD_SI;
      LD_SI:  state_nxt = RD_SJ;
      RD_SJ:  state_nxt = WT_SJ;
      WT_SJ:  state_nxt = LD_SJ;
      LD_SJ:  state_nxt = WR_SI;
      WR_SI:  state_nxt = WR_SJ;
      WR_SJ:  state_nxt = RD_F;
      RD_F:   state_nxt = WT_F;
      WT_F:   state_nxt = LD_F;
      LD_F:   state_nxt = WR_DEC;
      WR_DEC: begin
        if ((!dec_good && (ABORT_ON_BAD != 0)) || (k == LAST_K)) state_nxt = DONE;
        else                                                     state_nxt = RD_SI;
      end
      DONE:   if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i         <= 8'd0;
      j         <= 8'd0;
      k         <= 9'd0;
      si        <= 8'd0;
      sj        <= 8'd0;
      f         <= 8'd0;
      enc_b     <= 8'd0;
      key_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i         <= 8'd1;
            j         <= 8'd0;
            k         <= 9'd0;
            key_valid <= 1'b1;
          end
        end
        LD_SI: begin
          si <= s_q;
          j  <= j + s_q;
        end
        LD_SJ: sj <= s_q;
        LD_F: begin
          f     <= s_q;
          enc_b <= enc_q;
        end
        WR_DEC: begin
          if (!dec_good) key_valid <= 1'b0;
          i <= i + 8'd1;
          k <= k + 9'd1;
        end
        default: ;
      endcase
    end
  end

  // Read addresses are held through the wait and load cycles so the
  // registered memory output stays aligned with the load state.
  always_comb begin
    s_addr    = 8'd0;
    s_wr_data = 8'd0;
    s_wren    = 1'b0;
    enc_addr  = 5'd0;
    dec_addr  = 5'd0;
    dec_data  = 8'd0;
    dec_wren  = 1'b0;
    case (state)
      RD_SI, WT_SI, LD_SI: s_addr = i;
      RD_SJ, WT_SJ, LD_SJ: s_addr = j;
      WR_SI: begin
        s_addr    = i;
        s_wr_data = sj;
        s_wren    = 1'b1;
      end
      WR_SJ: begin
        s_addr    = j;
        s_wr_data = si;
        s_wren    = 1'b1;
      end
      RD_F, WT_F, LD_F: begin
        s_addr   = si + sj;
        enc_addr = k[4:0];
      end
      WR_DEC: begin
        dec_addr = k[4:0];
        dec_data = dec_byte;
        dec_wren = 1'b1;
      end
      default: ;
    endcase
  end

  assign fin  = (state == DONE);
  assign busy = (state != IDLE) && (state != DONE);

endmodule
`default_nettype wire

// File: tb/tb_rc4_prga_decrypt.sv
`default_nettype none
// ============================================================================
// tb_rc4_prga_decrypt : checks rc4_prga_decrypt (abort on and off) against an
//                       array-based RC4 reference model.  Rev 1.0
// ============================================================================
module tb_rc4_prga_decrypt;

  localparam int MSG_LEN = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       preload = 1'b0;
  logic [1:0] fin, busy, key_valid, s_wren, dec_wren;
  logic [7:0] s_addr [2];
  logic [7:0] s_wr_data [2];
  logic [7:0] s_q [2];
  logic [7:0] enc_q [2];
  logic [7:0] dec_data [2];
  logic [4:0] enc_addr [2];
  logic [4:0] dec_addr [2];

  logic [7:0] s_mem [2][256];
  logic [7:0] dec_ram [2][32];
  int         dec_cnt [2];
  int         s_wr_cnt [2];

  logic [7:0] ref_init [256];
  logic [7:0] enc_rom [32];
  logic [7:0] plain [32];
  logic [7:0] ks [32];
  logic [7:0] exp_dec [2][32];
  logic [7:0] exp_s [2][256];
  int         exp_n [2];
  logic       exp_kv [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  // Instance 0 aborts on the first bad byte, instance 1 runs every byte.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    rc4_prga_decrypt #(.MSG_LEN(MSG_LEN), .ABORT_ON_BAD(1 - g)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .fin(fin[g]), .busy(busy[g]),
      .key_valid(key_valid[g]), .s_addr(s_addr[g]), .s_wr_data(s_wr_data[g]),
      .s_wren(s_wren[g]), .s_q(s_q[g]), .enc_addr(enc_addr[g]), .enc_q(enc_q[g]),
      .dec_addr(dec_addr[g]), .dec_data(dec_data[g]), .dec_wren(dec_wren[g])
    );
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (preload) begin
        for (int x = 0; x < 256; x++) s_mem[g][x] <= ref_init[x];
        for (int x = 0; x < 32; x++) dec_ram[g][x] <= 8'hEE;
        dec_cnt[g]  <= 0;
        s_wr_cnt[g] <= 0;
      end else begin
        if (s_wren[g]) begin
          s_mem[g][s_addr[g]] <= s_wr_data[g];
          s_wr_cnt[g]         <= s_wr_cnt[g] + 1;
        end
        if (dec_wren[g]) begin
          dec_ram[g][dec_addr[g]] <= dec_data[g];
          dec_cnt[g]              <= dec_cnt[g] + 1;
        end
      end
      s_q[g]   <= s_mem[g][s_addr[g]];
      enc_q[g] <= enc_rom[enc_addr[g]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Plain RC4 PRGA on a copy of ref_init, decrypting enc_rom.
  task automatic model(input int g, input bit abort);
    logic [7:0] s [256];
    logic [7:0] i, j, t, d;
    for (int x = 0; x < 256; x++) s[x] = ref_init[x];
    i = 8'd0;
    j = 8'd0;
    exp_n[g]  = 0;
    exp_kv[g] = 1'b1;
    for (int k = 0; k < MSG_LEN; k++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      t = s[i] + s[j];
      d = s[t] ^ enc_rom[k];
      exp_dec[g][k] = d;
      exp_n[g]++;
      if (!(((d >= 8'h61) && (d <= 8'h7A)) || (d == 8'h20))) begin
        exp_kv[g] = 1'b0;
        if (abort) break;
      end
    end
    for (int x = 0; x < 256; x++) exp_s[g][x] = s[x];
  endtask

  task automatic build_enc();
    for (int k = 0; k < 32; k++) enc_rom[k] = 8'h00;
    model(1, 1'b0);
    for (int k = 0; k < 32; k++) begin
      ks[k]      = exp_dec[1][k];
      enc_rom[k] = ks[k] ^ plain[k];
    end
  endtask

  task automatic ksa_key();
    logic [7:0] key [3];
    logic [7:0] j, t;
    key = '{8'h4B, 8'h65, 8'h79};
    j = 8'd0;
    for (int x = 0; x < 256; x++) ref_init[x] = 8'(x);
    for (int x = 0; x < 256; x++) begin
      j = j + ref_init[x] + key[x % 3];
      t = ref_init[x]; ref_init[x] = ref_init[j]; ref_init[j] = t;
    end
  endtask

  task automatic rand_perm();
    logic [7:0] t;
    int y;
    for (int x = 0; x < 256; x++) ref_init[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      y = int'($urandom_range(x, 0));
      t = ref_init[x]; ref_init[x] = ref_init[y]; ref_init[y] = t;
    end
  endtask

  task automatic rand_text();
    int r;
    for (int k = 0; k < 32; k++) begin
      r = int'($urandom_range(26, 0));
      plain[k] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
    end
  endtask

  task automatic run_and_check(input string name);
    int cyc;
    int fin_cyc [2];
    int bad;
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
    model(0, 1'b1);
    model(1, 1'b0);
    start = 1'b1;
    cyc = 0;
    fin_cyc[0] = 0;
    fin_cyc[1] = 0;
    while ((fin_cyc[0] == 0 || fin_cyc[1] == 0) && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      for (int g = 0; g < 2; g++) if (fin[g] && fin_cyc[g] == 0) fin_cyc[g] = cyc;
    end
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s/fin%0d", name, g), fin[g], 1);
      check($sformatf("%s/latency%0d", name, g), fin_cyc[g], 1 + 12 * exp_n[g]);
      check($sformatf("%s/key_valid%0d", name, g), key_valid[g], exp_kv[g]);
      check($sformatf("%s/busy%0d", name, g), busy[g], 0);
      check($sformatf("%s/dec_writes%0d", name, g), dec_cnt[g], exp_n[g]);
      for (int k = 0; k < exp_n[g]; k++)
        check($sformatf("%s/dec%0d[%0d]", name, g, k), dec_ram[g][k], exp_dec[g][k]);
      bad = 0;
      for (int x = 0; x < 256; x++) if (s_mem[g][x] !== exp_s[g][x]) bad++;
      check($sformatf("%s/s_final%0d", name, g), bad, 0);
    end
  endtask

  task automatic finish_run(input string name);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%s/fin_clear", name), fin, 2'b00);
  endtask

  initial begin
    int cyc;
    int wr;
    string txt;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/fin", fin, 0);
    check("rst/busy", busy, 0);
    check("rst/key_valid", key_valid, 0);
    check("rst/s_wren", s_wren, 0);
    check("rst/dec_wren", dec_wren, 0);
    check("rst/s_addr", s_addr[0], 0);
    check("rst/enc_addr", enc_addr[0], 0);
    check("rst/dec_data", dec_data[0], 0);
    @(negedge clk); rst_n = 1'b1;

    // Identity S with zero ciphertext: first byte is S[2] = 0x02, bad.
    for (int x = 0; x < 256; x++) ref_init[x] = 8'(x);
    for (int k = 0; k < 32; k++) enc_rom[k] = 8'h00;
    run_and_check("ident");
    check("ident/dec0_const", dec_ram[0][0], 8'h02);
    check("ident/kv_const", key_valid[0], 0);

    // start held high in DONE must not restart the block.
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      check("hold/fin", fin, 2'b11);
    end
    check("hold/dec_writes", dec_cnt[0], 1);
    check("hold/s_writes", s_wr_cnt[0], 2);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check("drop/fin", fin, 2'b00);
    check("drop/busy", busy, 2'b00);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    check("restart/busy", busy, 2'b11);
    cyc = 0;
    while (fin != 2'b11 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("restart/fin", fin, 2'b11);
    finish_run("restart");

    // Key "Key", known plaintext.
    ksa_key();
    txt = "plaintext";
    for (int k = 0; k < 32; k++) plain[k] = (k < txt.len()) ? txt[k] : 8'h20;
    build_enc();
    run_and_check("key");
    check("key/dec0_const", dec_ram[0][0], 8'h70);
    check("key/kv_const", key_valid[0], 1);
    finish_run("key");

    // Same key, byte 5 decrypts to 'A'.
    enc_rom[5] = ks[5] ^ 8'h41;
    run_and_check("bad5");
    check("bad5/writes_const", dec_cnt[0], 6);
    finish_run("bad5");

    // Random S with S[1]=1 so the first swap has i == j.
    rand_perm();
    for (int x = 0; x < 256; x++) begin
      if (ref_init[x] == 8'd1) begin
        ref_init[x] = ref_init[1];
        ref_init[1] = 8'd1;
      end
    end
    rand_text();
    build_enc();
    run_and_check("ieqj");
    finish_run("ieqj");

    // Random permutations and text, sometimes with one uppercase byte.
    for (int n = 0; n < 3; n++) begin
      rand_perm();
      rand_text();
      build_enc();
      if ($urandom_range(1, 0) == 1) begin
        wr = int'($urandom_range(31, 0));
        enc_rom[wr] = ks[wr] ^ 8'(8'h41 + $urandom_range(25, 0));
      end
      run_and_check($sformatf("rand%0d", n));
      finish_run($sformatf("rand%0d", n));
    end

    // Reset asserted during WR_SI of byte 3 (seventh S write pulse).
    ksa_key();
    for (int k = 0; k < 32; k++) plain[k] = (k < txt.len()) ? txt[k] : 8'h20;
    build_enc();
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
    start = 1'b1;
    wr = 0;
    cyc = 0;
    while (wr < 7 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (s_wren[0]) wr++;
    end
    check("midrst/reached", wr, 7);
    rst_n = 1'b0;
    #1;
    check("midrst/fin", fin, 0);
    check("midrst/busy", busy, 0);
    check("midrst/key_valid", key_valid, 0);
    check("midrst/s_wren", s_wren, 0);
    check("midrst/s_addr", s_addr[0], 0);
    check("midrst/s_wr_data", s_wr_data[0], 0);
    check("midrst/dec_wren", dec_wren, 0);
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_and_check("after_rst");
    finish_run("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
